// File: rtl/mv_sequencer_if.sv
// Bundles the command, memory-read and result channels of mv_sequencer.
// The slave modport is the sequencer side; the master modport is the host/memory side.
`timescale 1ns/1ps
interface mv_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MAT_DIM    = 4
);
    localparam int IDX_W = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_arg;
    logic                  cmd_err;

    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    logic                  res_valid;
    logic                  res_ready;
    logic [IDX_W-1:0]      res_idx;
    logic [ACC_WIDTH-1:0]  res_data;

    logic                  busy;
    logic                  done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, mem_rd_data, res_ready,
        output cmd_ready, cmd_err, mem_rd_en, mem_rd_addr,
               res_valid, res_idx, res_data, busy, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_arg, mem_rd_data, res_ready,
        input  cmd_ready, cmd_err, mem_rd_en, mem_rd_addr,
               res_valid, res_idx, res_data, busy, done
    );
endinterface

// File: rtl/mv_sequencer.sv
// Command-driven NxN matrix-vector sequencer: loads the vector into a local register
// file, then streams weight rows through one MAC and emits one result per row.
`timescale 1ns/1ps
module mv_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MAT_DIM    = 4
) (
    input logic           clk,
    input logic           rst,
    mv_sequencer_if.slave bus
);
    localparam int IDX_W = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1;
    localparam logic [1:0] OP_SET_W = 2'b00;
    localparam logic [1:0] OP_SET_X = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(MAT_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] DIM_A    = ADDR_WIDTH'(MAT_DIM);

    typedef enum logic [2:0] {
        S_IDLE, S_LDX, S_LDX_WAIT, S_MAC, S_MAC_WAIT, S_EMIT
    } state_t;

    state_t r_state, w_state_next;

    logic [ADDR_WIDTH-1:0] r_w_base, r_x_base;
    logic [IDX_W-1:0]      r_row, r_j;
    logic                  r_pend_x, r_pend_w;
    logic [IDX_W-1:0]      r_pend_idx;
    logic [DATA_WIDTH-1:0] r_xreg [MAT_DIM];
    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  r_cmd_err, r_done;

    logic                  w_cmd_fire, w_res_fire, w_last_j, w_last_row;
    logic                  w_rd_en, w_acc_clear;
    logic [ADDR_WIDTH-1:0] w_rd_addr, w_row_off, w_j_a;
    logic [ACC_WIDTH-1:0]  w_w_ext, w_x_ext, w_prod;
    logic [DATA_WIDTH-1:0] w_x_sel;

    assign w_cmd_fire = bus.cmd_valid && (r_state == S_IDLE);
    assign w_res_fire = (r_state == S_EMIT) && bus.res_ready;
    assign w_last_j   = (r_j == LAST_IDX);
    assign w_last_row = (r_row == LAST_IDX);
    assign w_j_a      = ADDR_WIDTH'(r_j);
    assign w_row_off  = ADDR_WIDTH'(r_row) * DIM_A;

    // Sign-extend both operands; the product is kept to ACC_WIDTH bits (wrapping).
    assign w_x_sel = r_xreg[r_pend_idx];
    assign w_w_ext = {{(ACC_WIDTH-DATA_WIDTH){bus.mem_rd_data[DATA_WIDTH-1]}}, bus.mem_rd_data};
    assign w_x_ext = {{(ACC_WIDTH-DATA_WIDTH){w_x_sel[DATA_WIDTH-1]}}, w_x_sel};
    assign w_prod  = w_w_ext * w_x_ext;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_rd_addr    = '0;
        w_acc_clear  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire && bus.cmd_op == OP_RUN) w_state_next = S_LDX;
            end
            S_LDX: begin
                w_rd_en   = 1'b1;
                w_rd_addr = r_x_base + w_j_a;
                if (w_last_j) w_state_next = S_LDX_WAIT;
            end
            S_LDX_WAIT: begin
                w_acc_clear  = 1'b1;
                w_state_next = S_MAC;
            end
            S_MAC: begin
                w_rd_en   = 1'b1;
                w_rd_addr = r_w_base + w_row_off + w_j_a;
                if (w_last_j) w_state_next = S_MAC_WAIT;
            end
            S_MAC_WAIT: w_state_next = S_EMIT;
            S_EMIT: begin
                if (w_res_fire) begin
                    if (w_last_row) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_MAC;
                        w_acc_clear  = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_base   <= '0;
            r_x_base   <= '0;
            r_row      <= '0;
            r_j        <= '0;
            r_pend_x   <= 1'b0;
            r_pend_w   <= 1'b0;
            r_pend_idx <= '0;
            r_acc      <= '0;
            r_cmd_err  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_cmd_err  <= w_cmd_fire && (bus.cmd_op == OP_RSVD);
            r_done     <= w_res_fire && w_last_row;
            r_pend_x   <= (r_state == S_LDX);
            r_pend_w   <= (r_state == S_MAC);
            r_pend_idx <= r_j;
            if (w_cmd_fire) begin
                case (bus.cmd_op)
                    OP_SET_W: r_w_base <= bus.cmd_arg;
                    OP_SET_X: r_x_base <= bus.cmd_arg;
                    OP_RUN: begin
                        r_row <= '0;
                        r_j   <= '0;
                    end
                    default: ;
                endcase
            end
            if (w_rd_en) r_j <= w_last_j ? '0 : r_j + 1'b1;
            if (w_res_fire && !w_last_row) r_row <= r_row + 1'b1;
            // Read data arrives one cycle after its request, tagged by r_pend_*.
            if (w_acc_clear)   r_acc <= '0;
            else if (r_pend_w) r_acc <= r_acc + w_prod;
        end
    end

    generate
        for (genvar gi = 0; gi < MAT_DIM; gi++) begin : g_xreg
            always_ff @(posedge clk) begin
                if (r_pend_x && r_pend_idx == IDX_W'(gi)) r_xreg[gi] <= bus.mem_rd_data;
            end
        end
    endgenerate

    assign bus.cmd_ready   = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.cmd_err     = r_cmd_err;
    assign bus.done        = r_done;
    assign bus.mem_rd_en   = w_rd_en;
    assign bus.mem_rd_addr = w_rd_addr;
    assign bus.res_valid   = (r_state == S_EMIT);
    assign bus.res_idx     = (r_state == S_EMIT) ? r_row : '0;
    assign bus.res_data    = (r_state == S_EMIT) ? r_acc : '0;
endmodule
